// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, nibble codes and scan-state types shared by the
// display driver and the read-back monitor.
package seg7_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-low a..g patterns; a zero lights the segment.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] NIB_BLANK   = 4'hF;
    localparam logic [3:0] NIB_ILLEGAL = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } scan_state_e;

    function automatic logic one_hot_low(input logic [3:0] an);
        return $onehot(~an);
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] an);
        return !an[0] ? 2'd0 : !an[1] ? 2'd1 : !an[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-low a..g pattern back to its BCD nibble,
// flagging anything that is neither a digit nor blank.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_abcdefg,
    output logic [3:0] nibble,
    output logic       illegal
);

    always_comb begin
        nibble = NIB_ILLEGAL;
        case (seg_abcdefg)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: nibble = NIB_BLANK;
            default:   nibble = NIB_ILLEGAL;
        endcase
    end

    assign illegal = (nibble == NIB_ILLEGAL);

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: reads back a multiplexed active-low 4-digit 7-segment bus and
// publishes a coherent frame once every digit has been captured stable.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        frame_done,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] STABLE = STABLE_CYCLES[7:0];

    logic [11:0] sync1_q, sync2_q;
    logic [7:0]  cnt_q, cnt_d;
    scan_state_e state_q, state_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        capture;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic        illegal;

    seg7_pattern_decode u_decode (
        .seg_abcdefg (sync1_q[7:1]),
        .nibble      (nib),
        .illegal     (illegal)
    );

    // The counter tracks the stability of the sample entering sync2_q, so a
    // capture lands on the same edge that the count reaches STABLE.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        if (one_hot_low(sync1_q[11:8])) begin
            if (sync1_q != sync2_q) begin
                cnt_d   = 8'd1;
                state_d = ST_SETTLE;
            end else begin
                cnt_d   = (cnt_q == STABLE) ? cnt_q : cnt_q + 8'd1;
                state_d = (cnt_d == STABLE) ? ST_HELD : ST_SETTLE;
            end
        end
    end

    assign capture = (state_d == ST_HELD) && (state_q != ST_HELD);
    assign idx     = digit_index(sync1_q[11:8]);

    always_comb begin
        shadow_d     = shadow_q;
        sh_dp_d      = sh_dp_q;
        mask_d       = (mask_q == 4'hF) ? 4'h0 : mask_q;
        frame_done_d = (mask_q == 4'hF);
        digits_d     = frame_done_d ? shadow_q : digits_q;
        dp_d         = frame_done_d ? sh_dp_q : dp_q;
        err_d        = capture && illegal;
        err_cnt_d    = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        if (capture) begin
            shadow_d[{idx, 2'b00} +: 4] = nib;
            sh_dp_d[idx]                = ~sync1_q[SEG_DP];
            mask_d[idx]                 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            cnt_q        <= 8'd0;
            state_q      <= ST_IDLE;
            shadow_q     <= 16'hFFFF;
            sh_dp_q      <= 4'h0;
            mask_q       <= 4'h0;
            digits_q     <= 16'hFFFF;
            dp_q         <= 4'h0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            sync1_q      <= {an, seg};
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            sh_dp_q      <= sh_dp_d;
            mask_q       <= mask_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign digits     = digits_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: randomized and directed stimulus checked every cycle against
// a run-length based behavioural model of the display read-back.
module tb_seg7_scan_reader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg = 8'hFF;
    logic [3:0]  an = 4'hF;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_done, err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;
    int err_seen = 0;

    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    seg7_scan_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .digits(digits), .dp(dp),
        .frame_done(frame_done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: a digit is captured once, on the edge after S identical
    // consecutive pin samples showing a single selected digit.
    logic [11:0] m_last = 12'hFFF;
    int          m_run = 1;
    logic [15:0] m_shadow = 16'hFFFF;
    logic [3:0]  m_shdp = 4'h0, m_mask = 4'h0;
    logic        m_pend = 1'b0;
    logic [15:0] exp_digits = 16'hFFFF;
    logic [3:0]  exp_dp = 4'h0;
    logic        exp_fd = 1'b0, exp_err = 1'b0;
    logic [7:0]  exp_cnt = 8'h00;

    function automatic logic [3:0] m_decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pat[i] == s) return 4'(i);
        return (s == 7'h7F) ? 4'hF : 4'hE;
    endfunction

    function automatic int m_digit(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (a == ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 12'hFFF; m_run = 1; m_shadow = 16'hFFFF; m_shdp = 0; m_mask = 0;
            m_pend = 0; exp_digits = 16'hFFFF; exp_dp = 0; exp_fd = 0; exp_err = 0; exp_cnt = 0;
        end else begin
            exp_fd = m_pend;
            if (m_pend) begin
                exp_digits = m_shadow; exp_dp = m_shdp; m_mask = 0; m_pend = 0;
            end
            exp_err = 0;
            if (m_run == S && m_digit(m_last[11:8]) >= 0) begin
                int k;
                logic [3:0] v;
                k = m_digit(m_last[11:8]);
                v = m_decode(m_last[7:1]);
                m_shadow[k*4 +: 4] = v;
                m_shdp[k] = !m_last[0];
                if (v == 4'hE) begin
                    exp_err = 1;
                    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 1;
                end
                m_mask[k] = 1;
                if (m_mask == 4'hF) m_pend = 1;
            end
            if ({an, seg} == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else m_run = 1;
            m_last = {an, seg};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("digits", 32'(digits), 32'(exp_digits));
        chk("dp", 32'(dp), 32'(exp_dp));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        chk("err", 32'(err), 32'(exp_err));
        chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        if (frame_done === 1'b1) fd_seen++;
        if (err === 1'b1) err_seen++;
    end

    function automatic logic [7:0] enc(input int d, input bit dp_on);
        return {pat[d], ~dp_on};
    endfunction

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a;
        seg = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic scan(input int d0, input int d1, input int d2, input int d3, input logic [3:0] dps);
        hold(4'b1110, enc(d0, dps[0]), 8);
        hold(4'b1101, enc(d1, dps[1]), 8);
        hold(4'b1011, enc(d2, dps[2]), 8);
        hold(4'b0111, enc(d3, dps[3]), 8);
        hold(4'b1111, 8'hFF, 4);
    endtask

    initial begin
        int fd0, er0;
        repeat (3) @(negedge clk);
        chk("reset_digits", 32'(digits), 32'hFFFF);
        chk("reset_dp", 32'(dp), 32'h0);
        chk("reset_err_cnt", 32'(err_cnt), 32'h0);
        #1 rst_n = 1'b1;
        hold(4'hF, 8'hFF, 2);

        fd0 = fd_seen;
        scan(1, 2, 3, 4, 4'b0000);
        chk("scan_digits", 32'(digits), 32'h4321);
        chk("scan_model", 32'(exp_digits), 32'h4321);
        chk("scan_dp", 32'(dp), 32'h0);
        chk("scan_frames", 32'(fd_seen - fd0), 32'd1);
        chk("scan_no_err", 32'(err_seen), 32'd0);

        scan(5, 0, 6, 7, 4'b0100);
        chk("dp_digit2", 32'(digits[11:8]), 32'h6);
        chk("dp_bit2", 32'(dp), 32'b0100);
        chk("dp_digits", 32'(digits), 32'h7605);

        er0 = err_seen;
        an = 4'b1110; seg = {7'b0110110, 1'b1};
        repeat (8) @(negedge clk);
        #1;
        chk("illegal_cnt", 32'(err_cnt), 32'd1);
        chk("illegal_pulse", 32'(err_seen - er0), 32'd1);
        hold(4'b1101, enc(8, 0), 8);
        hold(4'b1011, enc(9, 0), 8);
        hold(4'b0111, 8'hFF, 8);
        hold(4'hF, 8'hFF, 4);
        chk("illegal_digits", 32'(digits), 32'hF98E);

        fd0 = fd_seen;
        hold(4'b1100, enc(8, 0), 3);
        hold(4'b1110, enc(1, 0), 8);
        hold(4'b1101, enc(2, 0), 8);
        hold(4'b1101, enc(8, 1), 3);
        hold(4'b1011, enc(3, 0), 8);
        hold(4'b0111, enc(4, 0), 8);
        hold(4'hF, 8'hFF, 4);
        chk("glitch_digits", 32'(digits), 32'h4321);
        chk("glitch_dp", 32'(dp), 32'h0);
        chk("glitch_err_cnt", 32'(err_cnt), 32'd1);
        chk("glitch_frames", 32'(fd_seen - fd0), 32'd1);

        for (int i = 0; i < 250; i++) begin
            logic [3:0] a;
            logic [7:0] s;
            a = ($urandom_range(0, 9) < 7) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            s = ($urandom_range(0, 9) < 8) ? enc($urandom_range(0, 9), 1'($urandom)) : 8'($urandom);
            hold(a, s, $urandom_range(1, 8));
        end
        hold(4'hF, 8'hFF, 4);

        fd0 = fd_seen;
        hold(4'b1110, enc(5, 0), 8);
        hold(4'b1101, enc(5, 0), 8);
        hold(4'b1011, enc(5, 0), 8);
        @(negedge clk) #2 rst_n = 1'b0;
        @(negedge clk) #2 rst_n = 1'b1;
        hold(4'hF, 8'hFF, 1);
        chk("rst_digits", 32'(digits), 32'hFFFF);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_no_frame", 32'(fd_seen - fd0), 32'd0);
        scan(9, 9, 9, 9, 4'b0000);
        chk("rst_nines", 32'(digits), 32'h9999);
        chk("rst_frames", 32'(fd_seen - fd0), 32'd1);

        er0 = err_seen;
        for (int i = 0; i < 300; i++) hold(i[0] ? 4'b1101 : 4'b1110, {7'b0110110, 1'b1}, 5);
        hold(4'hF, 8'hFF, 4);
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_model", 32'(exp_cnt), 32'hFF);
        chk("sat_pulses", 32'(err_seen - er0), 32'd300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Reads back a multiplexed, active-low, four-digit 7-segment display bus (segment lines plus digit-select lines) and reconstructs the BCD value and decimal point shown on each digit. It is the receiving end of the digit-to-segment encoding used by the display path. It sits beside the display driver as a self-check and monitor: it reports a coherent 4-digit frame once every digit has been observed stable, and it flags segment patterns that do not correspond to a legal digit.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before a digit is captured; legal range 2..255.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SEG  in  8  segment lines, active-low: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- AN  in  4  digit selects, active-low, one-hot-low when a digit is driven; bit0 = rightmost digit.
- DIGITS  out  16  last complete frame; nibble i = digit i (0..9, 4'hF blank, 4'hE illegal).
- DP  out  4  last complete frame decimal points, active-high, bit i = digit i.
- FRAME_DONE  out  1  one-cycle pulse when DIGITS/DP update.
- ERR  out  1  one-cycle pulse on capture of an illegal pattern.
- ERR_CNT  out  8  count of illegal captures, saturates at 8'hFF.

## Operation
- SEG and AN each pass through a two-flop synchroniser; reset value of the synchroniser flops is all ones (blank, no digit selected).
- Sample = {AN_sync, SEG_sync}. A stability counter clears to 1 whenever the sample differs from the previous cycle's sample, else increments, saturating at STABLE_CYCLES.
- States: IDLE (AN_sync not one-hot-low; counter held at 0, no capture), SETTLE (one-hot-low, counter < STABLE_CYCLES), HELD (counter reached STABLE_CYCLES, digit captured). IDLE->SETTLE on a one-hot-low sample; SETTLE->HELD on the edge where the counter reaches STABLE_CYCLES; any sample change -> SETTLE (or IDLE if not one-hot-low). Capture occurs exactly once per HELD entry.
- Reverse map of SEG[7:1] (dp ignored): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->4'hF (blank, legal), anything else->4'hE with ERR pulse and ERR_CNT increment.
- Capture writes shadow nibble and shadow dp (= ~SEG[0]) for the selected digit and sets its bit in a 4-bit seen mask.
- Recapturing a digit already in the mask overwrites its shadow value; mask unchanged.
- When the mask becomes 4'b1111: DIGITS/DP load from shadow, FRAME_DONE pulses, mask clears. Partial frames never reach DIGITS.

## Timing
- Reset values: DIGITS=16'hFFFF, DP=4'h0, FRAME_DONE=0, ERR=0, ERR_CNT=0; shadow=16'hFFFF, mask=0, state IDLE.
- Pins constant from before edge n: synchronised sample first valid at edge n+1; capture (shadow, ERR, ERR_CNT) at edge n+STABLE_CYCLES.
- FRAME_DONE and DIGITS/DP update one edge after the capture that completes the mask.
- ERR is registered with the capture: visible in the cycle after the capture edge, same cycle as the ERR_CNT change.
- Illegal capture completing a frame: ERR and FRAME_DONE both pulse, ERR one cycle earlier; DIGITS carries 4'hE.
- Glitch shorter than STABLE_CYCLES synchronised cycles: no capture, no pulses.
- Reset mid-frame: all state returns to reset values immediately; partial frame discarded.

## Structure
- Package seg7_pkg: segment pattern constants SEG_0..SEG_9, SEG_BLANK, nibble codes NIB_BLANK=4'hF, NIB_ILLEGAL=4'hE, segment bit-index constants. Shared with the display driver.
- Sub-module seg7_pattern_decode: combinational SEG[7:1] -> {nibble, illegal}. Synchroniser, FSM, shadow and frame logic live in the top.

## Test plan
- Reset, then drive AN=1110..0111 in turn, each held 8 cycles, patterns for 1,2,3,4 with dp off -> one FRAME_DONE, DIGITS=16'h4321, DP=0, ERR never asserted.
- Digit 2 shows 0100000 with dp on -> DIGITS[11:8]=6, DP[2]=1 after frame completes.
- SEG=0110110 on digit 0 held 8 cycles -> ERR pulse, ERR_CNT=1, after frame DIGITS[3:0]=4'hE.
- 3-cycle glitch to AN=1100, then normal scan (STABLE_CYCLES=4) -> no capture from the glitch, no ERR, frame values unchanged by it.
- Capture digits 0-2, assert RST_N low for 1 cycle, then scan full frame of 9s -> no FRAME_DONE before reset, DIGITS=16'hFFFF until new frame, then 16'h9999.
- 300 illegal captures -> ERR_CNT stops at 8'hFF, ERR still pulses each time.
